// File: rtl/csi_packet_parser.sv
// csi_packet_parser
//   Parses CSI-2 packet headers from lane-aligned 16-bit words
//   {lane0 byte, lane1 byte} (lane0 carries the earlier byte).
//   Short packets produce frame/line sync pulses; long packets produce a
//   byte-enabled payload stream. ECC is ignored and CRC bytes are dropped.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   word_in           aligned word {lane0[7:0], lane1[7:0]}
//   word_valid        high for the whole HS burst
//   pkt_valid         pulse when a complete header has been parsed
//   pkt_vc/dt/wc      virtual channel, data type, word count / short data
//   frame_start/end,
//   line_start/end    sync pulses for short packets DT 0x00..0x03
//   payload_data/be   payload word (earlier byte in [15:8]) and byte enables
//   payload_valid     payload_data/payload_be valid
//   payload_last      final payload word of a packet
//   pkt_err           pulse for a truncated packet or oversize word count
module csi_packet_parser #(
  parameter logic [15:0] MAX_WORD_COUNT = 16'd4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_valid,
  output logic        pkt_valid,
  output logic [1:0]  pkt_vc,
  output logic [5:0]  pkt_dt,
  output logic [15:0] pkt_wc,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [15:0] payload_data,
  output logic [1:0]  payload_be,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        pkt_err
);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, WAIT_END} state_t;

  state_t      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [7:0]  wc_lo_q, wc_lo_d;
  logic [15:0] rem_q, rem_d;

  logic        pkt_valid_q, pkt_valid_d;
  logic [1:0]  pkt_vc_q, pkt_vc_d;
  logic [5:0]  pkt_dt_q, pkt_dt_d;
  logic [15:0] pkt_wc_q, pkt_wc_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        line_start_q, line_start_d;
  logic        line_end_q, line_end_d;
  logic [15:0] payload_data_q, payload_data_d;
  logic [1:0]  payload_be_q, payload_be_d;
  logic        payload_valid_q, payload_valid_d;
  logic        payload_last_q, payload_last_d;
  logic        pkt_err_q, pkt_err_d;

  logic [15:0] wc_full;
  logic        is_short;

  always_comb begin
    state_d         = state_q;
    di_d            = di_q;
    wc_lo_d         = wc_lo_q;
    rem_d           = rem_q;
    pkt_valid_d     = 1'b0;
    pkt_vc_d        = pkt_vc_q;
    pkt_dt_d        = pkt_dt_q;
    pkt_wc_d        = pkt_wc_q;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    line_start_d    = 1'b0;
    line_end_d      = 1'b0;
    payload_data_d  = payload_data_q;
    payload_be_d    = '0;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    pkt_err_d       = 1'b0;

    wc_full  = {word_in[15:8], wc_lo_q};
    is_short = (di_q[5:0] < 6'h10);

    unique case (state_q)
      IDLE: begin
        if (word_valid) begin
          di_d    = word_in[15:8];
          wc_lo_d = word_in[7:0];
          state_d = HDR1;
        end
      end

      HDR1: begin
        if (word_valid) begin
          pkt_valid_d = 1'b1;
          pkt_vc_d    = di_q[7:6];
          pkt_dt_d    = di_q[5:0];
          pkt_wc_d    = wc_full;
          if (is_short) begin
            frame_start_d = (di_q[5:0] == 6'h00);
            frame_end_d   = (di_q[5:0] == 6'h01);
            line_start_d  = (di_q[5:0] == 6'h02);
            line_end_d    = (di_q[5:0] == 6'h03);
            state_d       = WAIT_END;
          end else if (wc_full == '0) begin
            state_d = WAIT_END;
          end else if (wc_full > MAX_WORD_COUNT) begin
            pkt_err_d = 1'b1;
            state_d   = WAIT_END;
          end else begin
            rem_d   = wc_full;
            state_d = PAYLOAD;
          end
        end else begin
          // Header cut short: report it, but never announce the packet.
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      PAYLOAD: begin
        if (word_valid) begin
          payload_valid_d = 1'b1;
          payload_data_d  = word_in;
          if (rem_q > 16'd2) begin
            payload_be_d = 2'b11;
            rem_d        = rem_q - 16'd2;
          end else if (rem_q == 16'd2) begin
            payload_be_d   = 2'b11;
            payload_last_d = 1'b1;
            state_d        = WAIT_END;
          end else begin
            // Odd count: low byte of this word is the first CRC byte.
            payload_be_d   = 2'b10;
            payload_last_d = 1'b1;
            state_d        = WAIT_END;
          end
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      WAIT_END: begin
        if (!word_valid) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      di_q            <= '0;
      wc_lo_q         <= '0;
      rem_q           <= '0;
      pkt_valid_q     <= 1'b0;
      pkt_vc_q        <= '0;
      pkt_dt_q        <= '0;
      pkt_wc_q        <= '0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      line_start_q    <= 1'b0;
      line_end_q      <= 1'b0;
      payload_data_q  <= '0;
      payload_be_q    <= '0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      pkt_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      di_q            <= di_d;
      wc_lo_q         <= wc_lo_d;
      rem_q           <= rem_d;
      pkt_valid_q     <= pkt_valid_d;
      pkt_vc_q        <= pkt_vc_d;
      pkt_dt_q        <= pkt_dt_d;
      pkt_wc_q        <= pkt_wc_d;
      frame_start_q   <= frame_start_d;
      frame_end_q     <= frame_end_d;
      line_start_q    <= line_start_d;
      line_end_q      <= line_end_d;
      payload_data_q  <= payload_data_d;
      payload_be_q    <= payload_be_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      pkt_err_q       <= pkt_err_d;
    end
  end

  assign pkt_valid     = pkt_valid_q;
  assign pkt_vc        = pkt_vc_q;
  assign pkt_dt        = pkt_dt_q;
  assign pkt_wc        = pkt_wc_q;
  assign frame_start   = frame_start_q;
  assign frame_end     = frame_end_q;
  assign line_start    = line_start_q;
  assign line_end      = line_end_q;
  assign payload_data  = payload_data_q;
  assign payload_be    = payload_be_q;
  assign payload_valid = payload_valid_q;
  assign payload_last  = payload_last_q;
  assign pkt_err       = pkt_err_q;

endmodule

// File: tb/tb_csi_packet_parser.sv
// tb_csi_packet_parser
//   Drives bursts of aligned words into csi_packet_parser and compares every
//   output cycle against a burst-level reference model of the packet format.
module tb_csi_packet_parser;

  localparam logic [15:0] MAX_WC = 16'd4096;

  logic        clk;
  logic        reset;
  logic [15:0] word_in;
  logic        word_valid;
  logic        pkt_valid;
  logic [1:0]  pkt_vc;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;
  logic        frame_start, frame_end, line_start, line_end;
  logic [15:0] payload_data;
  logic [1:0]  payload_be;
  logic        payload_valid, payload_last, pkt_err;

  csi_packet_parser #(.MAX_WORD_COUNT(MAX_WC)) dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .pkt_valid(pkt_valid), .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .payload_data(payload_data), .payload_be(payload_be),
    .payload_valid(payload_valid), .payload_last(payload_last),
    .pkt_err(pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for one cycle (slot s = outputs after the edge that
  // sampled burst word s, or the idle word following the burst).
  typedef struct {
    bit        hv;
    bit [1:0]  vc;
    bit [5:0]  dt;
    bit [15:0] wc;
    bit [3:0]  sync;
    bit        err;
    bit        pv;
    bit [15:0] pd;
    bit [1:0]  be;
    bit        last;
  } exp_t;

  logic [15:0] burst_q[$];
  exp_t        exp_a[];
  logic [15:0] mdata;

  // Reference: derive what a burst must produce from the packet layout.
  task automatic build_expect(input int gap);
    int len, nslots, nw;
    logic [7:0]  di;
    logic [15:0] wc;
    len    = burst_q.size();
    nslots = len + 1 + gap;
    exp_a  = new[nslots];
    if (len == 1) begin
      exp_a[1].err = 1'b1;
    end else if (len >= 2) begin
      di = burst_q[0][15:8];
      wc = {burst_q[1][15:8], burst_q[0][7:0]};
      exp_a[1].hv = 1'b1;
      exp_a[1].vc = di[7:6];
      exp_a[1].dt = di[5:0];
      exp_a[1].wc = wc;
      if (di[5:0] < 6'h10) begin
        if (di[5:0] < 6'h04) exp_a[1].sync = 4'b1000 >> di[1:0];
      end else if (wc > MAX_WC) begin
        exp_a[1].err = 1'b1;
      end else if (wc != 16'd0) begin
        nw = (int'(wc) + 1) / 2;
        for (int k = 0; k < nw; k++) begin
          if (2 + k < len) begin
            exp_a[2+k].pv   = 1'b1;
            exp_a[2+k].pd   = burst_q[2+k];
            exp_a[2+k].last = (k == nw - 1);
            exp_a[2+k].be   = (k == nw - 1 && wc[0]) ? 2'b10 : 2'b11;
          end
        end
        if (len < 2 + nw) exp_a[len].err = 1'b1;
      end
    end
  endtask

  task automatic check_slot(input int s);
    exp_t e;
    e = exp_a[s];
    if (e.pv) mdata = e.pd;
    check("pkt_valid", pkt_valid, e.hv);
    check("pkt_err", pkt_err, e.err);
    check("sync", {frame_start, frame_end, line_start, line_end}, e.sync);
    check("payload_valid", payload_valid, e.pv);
    check("payload_be", payload_be, e.be);
    check("payload_last", payload_last, e.last);
    check("payload_data", payload_data, mdata);
    if (e.hv) begin
      check("pkt_vc", pkt_vc, e.vc);
      check("pkt_dt", pkt_dt, e.dt);
      check("pkt_wc", pkt_wc, e.wc);
    end
  endtask

  // Called right after a check point (#1 past a rising edge).
  task automatic run_burst(input int gap);
    int len;
    len = burst_q.size();
    build_expect(gap);
    word_valid = (len > 0);
    word_in    = (len > 0) ? burst_q[0] : 16'($urandom);
    for (int s = 0; s < len + 1 + gap; s++) begin
      @(posedge clk);
      #1;
      check_slot(s);
      if (s + 1 < len) begin
        word_valid = 1'b1;
        word_in    = burst_q[s+1];
      end else begin
        word_valid = 1'b0;
        word_in    = 16'($urandom);
      end
    end
  endtask

  task automatic push_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    burst_q.push_back({vc, dt, wc[7:0]});
    burst_q.push_back({wc[15:8], 8'($urandom)});
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) burst_q.push_back(16'($urandom));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hdr"}, {pkt_valid, pkt_vc, pkt_dt, pkt_wc}, '0);
    check({tag, "_sync"}, {frame_start, frame_end, line_start, line_end}, '0);
    check({tag, "_pay"}, {payload_data, payload_be, payload_valid, payload_last}, '0);
    check({tag, "_err"}, pkt_err, 1'b0);
  endtask

  initial begin
    int wc, needed, len;
    logic [1:0] vc;
    logic [5:0] dt;

    reset      = 1'b1;
    word_valid = 1'b0;
    word_in    = '0;
    mdata      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Frame start short packet.
    burst_q = {16'h0001, {8'h00, 8'($urandom)}};
    run_burst(1);

    // Even long packet, RAW10, wc=6, CRC word and a trailer word.
    burst_q = {16'h2B06, 16'h0055, 16'h1122, 16'h3344, 16'h5566, 16'hC0C1, 16'hFFFF};
    run_burst(1);

    // Odd long packet, wc=5; low byte of last data word is CRC.
    burst_q = {16'h2B05, 16'h0033, 16'hAABB, 16'hCCDD, 16'hEE77, 16'h88FF};
    run_burst(0);

    // Truncated after two payload words, then a normal packet.
    burst_q.delete(); push_hdr(2'd1, 6'h2A, 16'd8); push_rand(2);
    run_burst(1);
    burst_q.delete(); push_hdr(2'd2, 6'h1E, 16'd4); push_rand(4);
    run_burst(1);

    // Oversize count.
    burst_q.delete(); push_hdr(2'd0, 6'h2B, 16'h2000); push_rand(6);
    run_burst(1);

    // Boundary counts: exactly MAX accepted, MAX+1 rejected.
    burst_q.delete(); push_hdr(2'd3, 6'h24, MAX_WC); push_rand(int'(MAX_WC) / 2 + 1);
    run_burst(1);
    burst_q.delete(); push_hdr(2'd3, 6'h24, MAX_WC + 16'd1); push_rand(4);
    run_burst(1);

    // Long packet with zero count, other short types, header cut short.
    burst_q.delete(); push_hdr(2'd1, 6'h2C, 16'd0); push_rand(2);
    run_burst(1);
    burst_q.delete(); push_hdr(2'd3, 6'h03, 16'h1234); run_burst(0);
    burst_q.delete(); push_hdr(2'd2, 6'h02, 16'h0007); push_rand(1); run_burst(0);
    burst_q.delete(); push_hdr(2'd0, 6'h01, 16'h0002); run_burst(0);
    burst_q.delete(); push_hdr(2'd1, 6'h08, 16'hBEEF); run_burst(1);
    burst_q = {16'h2B10};
    run_burst(1);
    burst_q.delete(); push_hdr(2'd0, 6'h2B, 16'd2); push_rand(1); run_burst(0);
    burst_q.delete(); push_hdr(2'd0, 6'h2B, 16'd1); push_rand(1); run_burst(0);

    // Reset in the middle of a payload, then a fresh burst.
    word_valid = 1'b1;
    word_in    = 16'h2B14;
    @(posedge clk); #1;
    word_in = 16'h0000;
    @(posedge clk); #1;
    word_in = 16'h1234;
    @(posedge clk); #1;
    word_in = 16'h5678;
    @(posedge clk); #1;
    reset      = 1'b1;
    word_valid = 1'b0;
    @(posedge clk); #1;
    check_all_zero("midreset");
    reset = 1'b0;
    mdata = '0;
    burst_q.delete(); push_hdr(2'd1, 6'h2B, 16'd3); push_rand(3);
    run_burst(1);

    // Randomized bursts.
    for (int b = 0; b < 300; b++) begin
      burst_q.delete();
      vc = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        dt = 6'($urandom_range(0, 15));
        wc = int'($urandom_range(0, 65535));
        needed = 2 + int'($urandom_range(0, 2));
      end else begin
        dt = 6'($urandom_range(16, 63));
        if ($urandom_range(0, 9) == 0) wc = int'($urandom_range(4097, 65535));
        else                           wc = int'($urandom_range(0, 24));
        needed = (wc > 4096) ? 4 : 2 + (wc + 1) / 2 + int'($urandom_range(1, 2));
      end
      push_hdr(vc, dt, 16'(wc));
      push_rand(needed - 2);
      if ($urandom_range(0, 3) == 0) begin
        len = int'($urandom_range(0, needed - 1));
        while (burst_q.size() > len) void'(burst_q.pop_back());
      end
      run_burst(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csi_packet_parser.md
Name: csi_packet_parser

Overview:
- Downstream of the two-lane word aligner. Consumes its lane-aligned 16-bit words, which are `{lane0 byte, lane1 byte}`; lane 0 carries the earlier byte of each pair.
- Parses CSI-2 packet headers. Emits frame/line sync pulses for short packets and a byte-enabled payload stream for long packets.
- Its output feeds the pixel unpacker.
- No ECC correction or CRC checking. The CRC bytes are discarded.

Parameters:
- MAX_WORD_COUNT, 16'd4096: largest accepted long-packet byte count. A larger count is flagged as an error and its payload is dropped.

Ports:
- clk  in  1  clock, shared with the aligner
- reset  in  1  synchronous, active-high reset
- word_in  in  16  aligned word `{lane0[7:0], lane1[7:0]}`
- word_valid  in  1  word_in valid; stays high for the whole HS burst
- pkt_valid  out  1  one-cycle pulse when a header has been parsed
- pkt_vc  out  2  virtual channel, `DI[7:6]`
- pkt_dt  out  6  data type, `DI[5:0]`
- pkt_wc  out  16  word count (long packet) or short-packet data field
- frame_start  out  1  pulse, short packet with DT=0x00
- frame_end  out  1  pulse, short packet with DT=0x01
- line_start  out  1  pulse, short packet with DT=0x02
- line_end  out  1  pulse, short packet with DT=0x03
- payload_data  out  16  payload bytes; bits [15:8] hold the earlier byte
- payload_be  out  2  byte enables; 2'b11 = both bytes valid, 2'b10 = upper byte only
- payload_valid  out  1  payload_data/payload_be valid this cycle
- payload_last  out  1  marks the final payload word of a packet
- pkt_err  out  1  one-cycle pulse for a truncated packet or an oversize word count

Behaviour:
- Every output is registered. On reset all outputs are 0 and the FSM enters IDLE; this holds even if reset arrives mid-packet.
- Latency: every output reflects the input word accepted on the previous clk edge.
- FSM states: IDLE, HDR1, PAYLOAD, WAIT_END.
- IDLE
  - When word_valid=1: latch `DI=word_in[15:8]` and `wc_lo=word_in[7:0]`, then go to HDR1.
- HDR1
  - When word_valid=1: `wc = {word_in[15:8], wc_lo}`; the ECC byte `word_in[7:0]` is ignored.
  - Next cycle: pkt_valid=1 with pkt_vc, pkt_dt and pkt_wc presented.
  - Short packet (DT < 0x10): pulse the matching sync output for DT 0x00..0x03 (none for other short DTs), then go to WAIT_END.
  - Long packet with wc=0: go to WAIT_END; no payload is emitted.
  - Long packet with wc > MAX_WORD_COUNT: pulse pkt_err in the same cycle as pkt_valid, then go to WAIT_END.
  - Otherwise: load `rem=wc` and go to PAYLOAD.
- PAYLOAD
  - On each word_valid=1 word: emit payload_valid=1 with `payload_data=word_in`.
  - If rem > 2: be=2'b11, rem -= 2.
  - If rem == 2: be=2'b11, payload_last=1, go to WAIT_END.
  - If rem == 1: be=2'b10, payload_last=1, go to WAIT_END. The low byte is CRC and is dropped.
- WAIT_END
  - Ignore all words, including CRC and trailer bytes.
  - When word_valid=0, go to IDLE.
- Truncation: word_valid=0 while in HDR1 or PAYLOAD → pulse pkt_err next cycle and go to IDLE. payload_last is never asserted for a truncated packet, and no pkt_valid is issued if the header was incomplete.
- Validity gating: pkt_valid and the sync pulses fire only after both header words have been seen with word_valid=1.
- Exactly one packet is parsed per word_valid burst.
- Output hygiene: payload_valid=0 whenever no payload word is emitted. payload_data holds its last value when not valid; payload_be=0 when not valid.
- Width: rem is 16 bits, and the subtraction never underflows because of the rem≤2 exits.

Test Plan:
- Short frame start: words 16'h0001, 16'h00xx, then word_valid=0 → pkt_valid with dt=0, vc=0, wc=1; frame_start pulses once; no payload.
- Long even packet: DI=0x2B (RAW10), wc=6, words 1122/3344/5566 + CRC → three payload words, be=11; payload_last on 5566; CRC ignored; pkt_err=0.
- Long odd packet: wc=5, words AABB/CCDD/EEcc + CRC → last word EEcc with be=10 and payload_last=1; total 5 bytes delivered.
- Truncation: wc=8, word_valid drops after 2 payload words → pkt_err pulses once, no payload_last; the next burst parses normally.
- Oversize: wc=16'h2000 with MAX_WORD_COUNT=4096 → pkt_valid and pkt_err pulse in the same cycle; no payload_valid for the whole burst.
- Reset mid-payload: assert reset during PAYLOAD → all outputs 0 the next cycle; a fresh burst after release gets a correct header parse.
